regfile_wr_arbiter: RTL and testbench

- Shares the single write port of the 16x16 register file between two producers: port A (ALU writeback) and port B (load/memory writeback).
- Round-robin arbitration with a valid/ready handshake; at most one write is issued per cycle.
- Keeps a 16-bit pending-write scoreboard so issue/hazard logic can stall on registers whose result is still in flight.
- Sits between the execute/memory stages and the register file's W1/D1/Wenable inputs.

---
 rtl/regfile_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (A) and load (B)
// writeback, with a pending-write scoreboard. Define RF_ARB_STATS_EN for grant/conflict counters.
module regfile_wr_arbiter #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_addr,
  input  logic [DW-1:0]    a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [AW-1:0]    b_addr,
  input  logic [DW-1:0]    b_data,
  output logic             b_ready,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rsv_err,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic [2**AW-1:0] busy
`ifdef RF_ARB_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      a_grant_cnt,
  output logic [15:0]      b_grant_cnt,
  output logic [15:0]      conflict_cnt
`endif
);

  localparam int unsigned NR = 2**AW;

  logic          prio_a_q, prio_a_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [NR-1:0] busy_q, busy_d;
  logic          rsv_err_q, rsv_err_d;
  logic          gnt;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;

  always_comb begin
    a_ready   = reset_n & a_valid & (~b_valid | prio_a_q);
    b_ready   = reset_n & b_valid & (~a_valid | ~prio_a_q);
    gnt       = a_ready | b_ready;
    gnt_addr  = a_ready ? a_addr : b_addr;
    gnt_data  = a_ready ? a_data : b_data;

    prio_a_d  = prio_a_q;
    if (a_ready) begin
      prio_a_d = 1'b0;
    end else if (b_ready) begin
      prio_a_d = 1'b1;
    end

    wr_en_d   = gnt;
    wr_addr_d = gnt ? gnt_addr : wr_addr_q;
    wr_data_d = gnt ? gnt_data : wr_data_q;

    // Clear before set so a new reservation at the retiring register keeps it busy.
    busy_d    = busy_q;
    if (gnt) begin
      busy_d[gnt_addr] = 1'b0;
    end
    rsv_err_d = rsv_valid & busy_q[rsv_addr] & ~(gnt & (gnt_addr == rsv_addr));
    if (rsv_valid) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prio_a_q  <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      prio_a_q  <= prio_a_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      rsv_err_q <= rsv_err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign rsv_err = rsv_err_q;

`ifdef RF_ARB_STATS_EN
  logic [15:0] a_cnt_q, a_cnt_d;
  logic [15:0] b_cnt_q, b_cnt_d;
  logic [15:0] c_cnt_q, c_cnt_d;

  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    c_cnt_d = c_cnt_q;
    if (stats_clr) begin
      a_cnt_d = '0;
      b_cnt_d = '0;
      c_cnt_d = '0;
    end else begin
      if (a_ready && a_cnt_q != 16'hFFFF) a_cnt_d = a_cnt_q + 16'd1;
      if (b_ready && b_cnt_q != 16'hFFFF) b_cnt_d = b_cnt_q + 16'd1;
      if (a_valid && b_valid && c_cnt_q != 16'hFFFF) c_cnt_d = c_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      c_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      c_cnt_q <= c_cnt_d;
    end
  end

  assign a_grant_cnt  = a_cnt_q;
  assign b_grant_cnt  = b_cnt_q;
  assign conflict_cnt = c_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: a driver predicts grants and per-cycle outputs,
// a negedge monitor pops the predictions and compares them with the registered outputs.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, rsv_valid = 1'b0;
  logic [3:0]  a_addr = '0, b_addr = '0, rsv_addr = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, rsv_err, wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data, busy;
`ifdef RF_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] a_grant_cnt, b_grant_cnt, conflict_cnt;
`endif

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.AW(4), .DW(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_err   (rsv_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
`ifdef RF_ARB_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .a_grant_cnt  (a_grant_cnt),
    .b_grant_cnt  (b_grant_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  typedef struct {
    logic        en;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [15:0] bsy;
    logic        err;
  } exp_t;

  exp_t expq[$];
  int total = 0;
  int bad = 0;

  // Reference model state: which port is favoured, register file port view, reservations.
  bit          fav_a = 1'b1;
  logic        m_en = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  bit          m_busy[16];
  logic        m_err = 1'b0;

  // Producers: a pending request is held until the model says it was accepted.
  bit          pa = 1'b0, pb = 1'b0;
  logic [3:0]  aa = '0, ba = '0;
  logic [15:0] ad = '0, bd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic set_a(input logic [3:0] addr, input logic [15:0] data);
    pa = 1'b1; aa = addr; ad = data;
  endtask

  task automatic set_b(input logic [3:0] addr, input logic [15:0] data);
    pb = 1'b1; ba = addr; bd = data;
  endtask

  function automatic logic [15:0] busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic cycle(input bit rst, input bit rv, input logic [3:0] ra);
    bit ga, gb;
    @(posedge clk);
    #1;
    reset_n   = !rst;
    a_valid   = pa; a_addr = aa; a_data = ad;
    b_valid   = pb; b_addr = ba; b_data = bd;
    rsv_valid = rv; rsv_addr = ra;
    #2;
    ga = !rst && pa && (!pb || fav_a);
    gb = !rst && pb && (!pa || !fav_a);
    chk("a_ready", {31'd0, a_ready}, {31'd0, ga});
    chk("b_ready", {31'd0, b_ready}, {31'd0, gb});
    if (rst) begin
      fav_a = 1'b1; m_en = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
    end else begin
      m_err = rv && m_busy[ra] && !((ga && aa == ra) || (gb && ba == ra));
      m_en  = ga || gb;
      if (ga) begin
        m_addr = aa; m_data = ad; m_busy[aa] = 1'b0; fav_a = 1'b0; pa = 1'b0;
      end else if (gb) begin
        m_addr = ba; m_data = bd; m_busy[ba] = 1'b0; fav_a = 1'b1; pb = 1'b0;
      end
      if (rv) m_busy[ra] = 1'b1;
    end
    expq.push_back('{m_en, m_addr, m_data, busy_vec(), m_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0);
  endtask

  // The newest entry belongs to the edge still ahead, so only older entries are checked.
  always @(negedge clk) begin
    if (expq.size() > 1) begin
      exp_t e;
      e = expq.pop_front();
      chk("wr_en",   {31'd0, wr_en},   {31'd0, e.en});
      chk("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
      chk("wr_data", {16'd0, wr_data}, {16'd0, e.data});
      chk("busy",    {16'd0, busy},    {16'd0, e.bsy});
      chk("rsv_err", {31'd0, rsv_err}, {31'd0, e.err});
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
    cycle(1'b1, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0);

    // Single writer
    set_a(4'd3, 16'h1234);
    idle(3);

    // Contention fairness from reset
    cycle(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      if (!pa) set_a(4'd1, 16'(16'h0100 + i));
      if (!pb) set_b(4'd2, 16'(16'h0200 + i));
      cycle(1'b0, 1'b0, 4'd0);
    end
    pa = 1'b0; pb = 1'b0;
    idle(2);

    // Same-address conflict
    cycle(1'b1, 1'b0, 4'd0);
    set_a(4'd5, 16'hAAAA);
    set_b(4'd5, 16'hBBBB);
    idle(3);

    // Scoreboard set/clear, then set coinciding with clear
    cycle(1'b0, 1'b1, 4'd7);
    idle(2);
    set_a(4'd7, 16'h7777);
    idle(2);
    cycle(1'b0, 1'b1, 4'd7);
    idle(1);
    set_a(4'd7, 16'h7778);
    cycle(1'b0, 1'b1, 4'd7);
    idle(1);
    set_a(4'd7, 16'h7779);
    idle(2);

    // Reservation error
    cycle(1'b0, 1'b1, 4'd9);
    idle(1);
    cycle(1'b0, 1'b1, 4'd9);
    idle(2);

    // Reset mid-operation with busy = 00F0
    set_a(4'd9, 16'h9999);
    cycle(1'b0, 1'b1, 4'd4);
    cycle(1'b0, 1'b1, 4'd5);
    cycle(1'b0, 1'b1, 4'd6);
    cycle(1'b0, 1'b1, 4'd7);
    set_a(4'd4, 16'h4444);
    set_b(4'd6, 16'h6666);
    cycle(1'b1, 1'b0, 4'd0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!pa && $urandom_range(0, 2) != 0) set_a(4'($urandom_range(0, 15)), 16'($urandom));
      if (!pb && $urandom_range(0, 2) != 0) set_b(4'($urandom_range(0, 15)), 16'($urandom));
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
    end
    pa = 1'b0; pb = 1'b0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
